fifo_pull_stage: RTL
====================

# fifo_pull_stage

Read-side companion to the team FIFO. It drives the FIFO read port, whose data returns one cycle after a pull. It absorbs that latency in a small registered buffer and re-presents the data as a standard valid/ready stream with no combinational path from downstream `ready_i` to the FIFO. It sits between a FIFO instance and any consumer that needs plain valid/ready semantics with zero-bubble throughput.

## Interface
- `DATA_WIDTH`, 8, payload width; 0 is fatal at elaboration.
- `BUF_DEPTH`, 3, buffer entries; 0 is fatal; ≥3 required for one transfer per cycle.
- `CNT_WIDTH`, `$clog2(BUF_DEPTH+1)`, width of `level_o`.
- `clk_i`  in  1  single clock, all logic on rising edge.
- `rst_n_i`  in  1  reset; synchronous, active-low.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_valid_i`  in  1  FIFO `read_valid_o`; high one cycle after an accepted pull.
- `fifo_data_i`  in  DATA_WIDTH  FIFO `data_out_o`; meaningful only with `fifo_valid_i`.
- `fifo_ready_o`  out  1  to FIFO `read_ready_i`; pull request.
- `valid_o`  out  1  downstream data valid.
- `data_o`  out  DATA_WIDTH  downstream payload; `'0` when `valid_o` low.
- `ready_i`  in  1  downstream ready.
- `level_o`  out  CNT_WIDTH  entries currently buffered.
- `err_o`  out  1  sticky protocol error.

## Operation
- State:
  - `count` (0..BUF_DEPTH).
  - `inflight_q` (1 bit).
  - Circular entry array with `wr_ptr`/`rd_ptr` modulo BUF_DEPTH; BUF_DEPTH need not be a power of 2, so pointers wrap explicitly from BUF_DEPTH-1 to 0.
  - `err_q`.
- Pull: `fifo_ready_o = rst_n_i && !fifo_empty_i && (count + inflight_q < BUF_DEPTH)`. It depends only on registers, `fifo_empty_i` and reset. Never pull from an empty FIFO.
- `inflight_q <= fifo_ready_o` each cycle. It equals the FIFO's registered `read_valid_o` prediction.
- Push: when `fifo_valid_i`, write `fifo_data_i` at `wr_ptr`, advance `wr_ptr`.
- Pop: when `valid_o && ready_i`, advance `rd_ptr`.
- Counting:
  - `count` changes by +push −pop.
  - Simultaneous push and pop leaves `count` unchanged.
  - Push into a full buffer cannot occur by construction. If it is attempted, drop the data and set `err_q`.
- `valid_o = (count != 0)`, `data_o = valid_o ? entry[rd_ptr] : '0`, `level_o = count`.
- Error: set `err_q` when `fifo_valid_i != inflight_q`, or on a push while full. It clears only on reset. `err_o = err_q`.
- Simulation-only checks (excluded when `synthesis` is defined):
  - Assert `!(valid_o && count == 0)`.
  - Assert `count <= BUF_DEPTH`.
  - Warn once on `err_q` rising.

## Timing
- Reset (`rst_n_i` low at a rising edge): `count`, pointers, `inflight_q` and `err_q` go to 0, and the entry array clears. Outputs from the next cycle:
  - `valid_o`=0, `data_o`=0, `level_o`=0, `err_o`=0.
  - `fifo_ready_o`=0 combinationally while `rst_n_i` is low.
- Reset mid-operation discards buffered and in-flight data.
  - A FIFO reset on the same `rst_n_i` keeps both sides consistent.
  - A `fifo_valid_i` in the first cycle after reset deasserts flags `err_o`.
- Latency:
  - `fifo_ready_o` high at cycle t → `fifo_valid_i` at t+1 → `valid_o` at t+2.
  - From FIFO non-empty to `valid_o` is 2 cycles.
- Throughput: with BUF_DEPTH≥3 and `ready_i` held high, one word per cycle in steady state.
- Downstream stall: pulling stops once `count + inflight_q == BUF_DEPTH`, and the buffer settles at BUF_DEPTH entries.
- Handshake: `valid_o`/`data_o` stay stable until accepted; a transfer occurs on `valid_o && ready_i` at the clock edge.

## Structure
- Add `FIFO_READ_LATENCY = 1` to the shared `fifo_pkg`, with `PULL_MIN_DEPTH = FIFO_READ_LATENCY + 2`. The elaboration check warns if `BUF_DEPTH < PULL_MIN_DEPTH`.
- No typedefs needed.
- No sub-module: the entry array and pointers are a few registers and stay inline.

## Test plan
- Reset with the FIFO holding 4 words → `fifo_ready_o`=0 during reset; `valid_o`=0, `data_o`=0, `level_o`=0 for the cycle after reset.
- Write 0x11..0x18 into a FIFO of depth 16 with `ready_i`=1 throughout → words appear on `data_o` in order. `valid_o` rises 2 cycles after FIFO non-empty, then stays high for 8 consecutive cycles.
- Same 8 words with `ready_i`=0 → `fifo_ready_o` drops after 3 pulls and `level_o` settles at 3. Raising `ready_i` drains 0x11..0x18 in order with no loss or duplicate.
- `ready_i` toggling 1,0,1,0 over 16 words → all 16 words arrive in order. `level_o` never exceeds 3, `err_o` stays 0.
- Force `fifo_valid_i`=1 with `inflight_q`=0 for one cycle → `err_o`=1 next cycle, staying set until reset.
- FIFO goes empty mid-stream (5 words, then a gap) → no pull while `fifo_empty_i`=1. Buffered words drain, then `valid_o`=0 and `data_o`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the team FIFO and its read-side helpers.
package fifo_pkg;

    localparam int unsigned FIFO_READ_LATENCY = 1;
    // Read latency plus one slot to cover the registered pull decision and one for the consumer.
    localparam int unsigned PULL_MIN_DEPTH    = FIFO_READ_LATENCY + 2;

endpackage

// File: rtl/fifo_pull_stage.sv
// Read-side companion to the team FIFO: absorbs the one-cycle read latency in a small
// circular buffer and re-presents the data as a valid/ready stream.
module fifo_pull_stage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 3,
    parameter int unsigned CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_valid_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  level_o,
    output logic                  err_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = CNT_WIDTH + 1;

    if (DATA_WIDTH == 0) begin : g_bad_width
        $fatal(1, "fifo_pull_stage: DATA_WIDTH must be non-zero");
    end
    if (BUF_DEPTH == 0) begin : g_bad_depth
        $fatal(1, "fifo_pull_stage: BUF_DEPTH must be non-zero");
    end
    if (BUF_DEPTH < PULL_MIN_DEPTH) begin : g_shallow_depth
        $warning("fifo_pull_stage: BUF_DEPTH below PULL_MIN_DEPTH, throughput reduced");
    end

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_inflight;
    logic                  r_err;

    logic [OCC_W-1:0]      w_occ;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop;
    logic                  w_valid;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy includes the word already requested but not yet returned.
    assign w_occ        = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign fifo_ready_o = rst_n_i && !fifo_empty_i && (w_occ < OCC_W'(BUF_DEPTH));

    assign w_full    = (r_count == CNT_WIDTH'(BUF_DEPTH));
    assign w_push_ok = fifo_valid_i && !w_full;
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && ready_i;

    assign valid_o = w_valid;
    assign data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign level_o = r_count;
    assign err_o   = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_mem      <= '{default: '0};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= fifo_ready_o;
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= fifo_data_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
            // Returned data must match the predicted read-valid; a push into a full buffer is dropped.
            if ((fifo_valid_i != r_inflight) || (fifo_valid_i && w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifndef synthesis
    logic r_err_warned;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_err_warned <= 1'b0;
        end else if (r_err && !r_err_warned) begin
            r_err_warned <= 1'b1;
            $warning("fifo_pull_stage: read-side protocol error latched");
        end
    end

    a_valid_has_data: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(valid_o && (r_count == '0)));
    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        r_count <= CNT_WIDTH'(BUF_DEPTH));
`endif

endmodule
